// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode/state enums and default widths for the ALU sequencer
package alu_pkg;

   localparam int XLEN_DEF    = 32;
   localparam int SHAMT_W_DEF = 5;

   typedef enum logic [3:0] {
      OP_ADD   = 4'b0000,
      OP_SUB   = 4'b0001,
      OP_XOR   = 4'b0010,
      OP_OR    = 4'b0011,
      OP_AND   = 4'b0100,
      OP_SLT   = 4'b0101,
      OP_SLTU  = 4'b0110,
      OP_SLL   = 4'b0111,
      OP_SRL   = 4'b1000,
      OP_SRA   = 4'b1001,
      OP_PASSA = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } seq_state_e;

   function automatic logic is_shift_op(input alu_op_e op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_seq_shift_unit.sv
// rtl/alu_seq_shift_unit.sv - one-bit shift step, or full barrel shift when ALU_SEQ_FAST_SHIFT_EN is defined
module alu_seq_shift_unit
   import alu_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF
`ifdef ALU_SEQ_FAST_SHIFT_EN
   ,
   parameter int SHAMT_W = SHAMT_W_DEF
`endif
) (
   input  alu_op_e           op,
   input  logic [XLEN-1:0]   data,
`ifdef ALU_SEQ_FAST_SHIFT_EN
   input  logic [SHAMT_W-1:0] shamt,
`endif
   output logic [XLEN-1:0]   result
);

`ifdef ALU_SEQ_FAST_SHIFT_EN
   always_comb begin
      result = data;
      case (op)
         OP_SLL:  result = data << shamt;
         OP_SRL:  result = data >> shamt;
         OP_SRA:  result = XLEN'($signed(data) >>> shamt);
         default: result = data;
      endcase
   end
`else
   always_comb begin
      result = data;
      case (op)
         OP_SLL:  result = {data[XLEN-2:0], 1'b0};
         OP_SRL:  result = {1'b0, data[XLEN-1:1]};
         OP_SRA:  result = {data[XLEN-1], data[XLEN-1:1]};
         default: result = data;
      endcase
   end
`endif

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - one-op-in-flight ALU sequencer; ALU_SEQ_FAST_SHIFT_EN selects single-cycle shifts
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int SHAMT_W = SHAMT_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_op,
   input  logic [XLEN-1:0] in_opa,
   input  logic [XLEN-1:0] in_opb,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            out_err,
   output logic            busy
);

`ifdef ALU_SEQ_FAST_SHIFT_EN
   localparam bit ITER_SHIFT = 1'b0;
`else
   localparam bit ITER_SHIFT = 1'b1;
`endif

   seq_state_e         state_q;
   logic               out_valid_q;
   logic               out_err_q;
   logic [XLEN-1:0]    out_result_q;
   logic [XLEN-1:0]    acc_q;
   logic [SHAMT_W-1:0] cnt_q;
   alu_op_e            sop_q;

   alu_op_e            op_in;
   logic [SHAMT_W-1:0] shamt_in;
   logic [XLEN-1:0]    shift_res;
   logic [XLEN-1:0]    alu_res;
   logic               alu_err;

   assign op_in    = alu_op_e'(in_op);
   assign shamt_in = in_opb[SHAMT_W-1:0];

`ifdef ALU_SEQ_FAST_SHIFT_EN
   alu_seq_shift_unit #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_shift (
      .op     (op_in),
      .data   (in_opa),
      .shamt  (shamt_in),
      .result (shift_res)
   );
`else
   alu_seq_shift_unit #(.XLEN(XLEN)) u_shift (
      .op     (sop_q),
      .data   (acc_q),
      .result (shift_res)
   );
`endif

   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (op_in)
         OP_ADD:   alu_res = in_opa + in_opb;
         OP_SUB:   alu_res = in_opa - in_opb;
         OP_XOR:   alu_res = in_opa ^ in_opb;
         OP_OR:    alu_res = in_opa | in_opb;
         OP_AND:   alu_res = in_opa & in_opb;
         OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(in_opa) < $signed(in_opb))};
         OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (in_opa < in_opb)};
         OP_PASSA: alu_res = in_opa;
`ifdef ALU_SEQ_FAST_SHIFT_EN
         OP_SLL, OP_SRL, OP_SRA: alu_res = shift_res;
`else
         // Only a zero shift amount reaches here; nonzero shifts go through ST_SHIFT.
         OP_SLL, OP_SRL, OP_SRA: alu_res = in_opa;
`endif
         default:  alu_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         out_valid_q  <= 1'b0;
         out_err_q    <= 1'b0;
         out_result_q <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
         sop_q        <= OP_ADD;
      end else if (flush) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  if (ITER_SHIFT && is_shift_op(op_in) && (shamt_in != '0)) begin
                     acc_q   <= in_opa;
                     cnt_q   <= shamt_in;
                     sop_q   <= op_in;
                     state_q <= ST_SHIFT;
                  end else begin
                     out_result_q <= alu_res;
                     out_err_q    <= alu_err;
                     out_valid_q  <= 1'b1;
                     state_q      <= ST_DONE;
                  end
               end
            end
            ST_SHIFT: begin
               acc_q <= shift_res;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == SHAMT_W'(1)) begin
                  out_result_q <= shift_res;
                  out_err_q    <= 1'b0;
                  out_valid_q  <= 1'b1;
                  state_q      <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready   = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_err    = out_err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - scoreboard bench for alu_seq_ctrl (honours ALU_SEQ_FAST_SHIFT_EN)
module tb_alu_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_op = 4'b0;
   logic [31:0] in_opa = '0;
   logic [31:0] in_opb = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_err;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_res_q[$];
   bit          exp_err_q[$];
   int          exp_lat_q[$];
   string       name_q[$];

   alu_seq_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_opa     (in_opa),
      .in_opb     (in_opb),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_err    (out_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_SEQ_FAST_SHIFT_EN
      return 1;
`else
      if ((op == 4'b0111 || op == 4'b1000 || op == 4'b1001) && b[4:0] != 5'd0)
         return int'(b[4:0]) + 1;
      return 1;
`endif
   endfunction

   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output bit e);
      logic [63:0] sx;
      r = '0;
      e = 1'b0;
      sx = {{32{a[31]}}, a};
      case (op)
         4'b0000: r = a + b;
         4'b0001: r = a + ~b + 32'd1;
         4'b0010: r = a ^ b;
         4'b0011: r = a | b;
         4'b0100: r = a & b;
         4'b0101: r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
         4'b0110: r = {31'd0, a < b};
         4'b0111: r = a << b[4:0];
         4'b1000: r = a >> b[4:0];
         4'b1001: begin sx = sx >> b[4:0]; r = sx[31:0]; end
         4'b1111: r = a;
         default: e = 1'b1;
      endcase
   endfunction

   task automatic send_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      for (int k = 0; k < 50 && !in_ready; k++) begin
         @(posedge clk); #1;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL send_ready: in_ready=%b required 1", in_ready);
      end
      in_valid = 1'b1;
      in_op    = op;
      in_opa   = a;
      in_opb   = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_opa   = $urandom;
      in_opb   = $urandom;
   endtask

   task automatic sb_check();
      int lat;
      logic [31:0] er;
      bit ee;
      int el;
      string nm;
      lat = 1;
      while (!out_valid && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      er = exp_res_q.pop_front();
      ee = exp_err_q.pop_front();
      el = exp_lat_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_valid: no out_valid within %0d cycles", nm, lat);
      end
      n_checks++;
      if (out_result !== er) begin
         n_fail++;
         $display("FAIL %s_result: got %h required %h", nm, out_result, er);
      end
      n_checks++;
      if (out_err !== ee) begin
         n_fail++;
         $display("FAIL %s_err: got %b required %b", nm, out_err, ee);
      end
      n_checks++;
      if (lat !== el) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d required %0d", nm, lat, el);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input bit e);
      exp_res_q.push_back(r);
      exp_err_q.push_back(e);
      exp_lat_q.push_back(exp_lat(op, b));
      name_q.push_back(nm);
      send_op(op, a, b);
      sb_check();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({out_valid, out_err, busy, in_ready} !== 4'b0001 || out_result !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_state: v/e/busy/rdy=%b%b%b%b res=%h required 0001 res=0",
                  out_valid, out_err, busy, in_ready, out_result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_arith();
      run_op("add_wrap", 4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
      run_op("sub_neg",  4'b0001, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0);
   endtask

   task automatic test_compare_illegal();
      run_op("slt",     4'b0101, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0);
      run_op("sltu",    4'b0110, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
      run_op("illegal", 4'b1100, 32'h1234_5678, 32'h9, 32'h0, 1'b1);
      run_op("passa",   4'b1111, 32'hCAFE_F00D, 32'h1, 32'hCAFE_F00D, 1'b0);
   endtask

   task automatic test_shifts();
      run_op("sra4",  4'b1001, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0);
      run_op("sll31", 4'b0111, 32'h1, 32'h1F, 32'h8000_0000, 1'b0);
      run_op("srl0",  4'b1000, 32'hA5A5_0F0F, 32'h20, 32'hA5A5_0F0F, 1'b0);
   endtask

   task automatic test_random();
      logic [3:0] ops [12];
      logic [31:0] a, b, r;
      bit e;
      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
              4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1111, 4'b1011};
      for (int i = 0; i < 16; i++) begin
         logic [3:0] op;
         op = ops[$urandom_range(0, 11)];
         a  = $urandom;
         b  = $urandom;
         model(op, a, b, r, e);
         run_op($sformatf("rand%0d", i), op, a, b, r, e);
      end
   endtask

   task automatic test_backpressure();
      bit bad;
      send_op(4'b0000, 32'd10, 32'd20);
      for (int k = 0; k < 64 && !out_valid; k++) begin
         @(posedge clk); #1;
      end
      bad = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (out_valid !== 1'b1 || out_result !== 32'd30 || in_ready !== 1'b0) bad = 1'b1;
         @(posedge clk); #1;
      end
      n_checks++;
      if (bad || out_result !== 32'd30) begin
         n_fail++;
         $display("FAIL backpressure_hold: res=%h v=%b rdy=%b required 0000001e/1/0",
                  out_result, out_valid, in_ready);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_fail++;
         $display("FAIL backpressure_release: rdy/v/busy=%b%b%b required 100", in_ready, out_valid, busy);
      end
   endtask

   task automatic test_flush();
      bit seen;
      send_op(4'b0111, 32'h1, 32'd20);
      @(posedge clk); #1;
      flush = 1'b1;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_op = 4'b0000;
      @(posedge clk); #1;
      flush = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if ({busy, in_ready, out_valid} !== 3'b010) begin
         n_fail++;
         $display("FAIL flush_idle: busy/rdy/v=%b%b%b required 010", busy, in_ready, out_valid);
      end
      seen = 1'b0;
      for (int k = 0; k < 25; k++) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL flush_no_result: out_valid=%b required 0", seen);
      end
      run_op("add_after_flush", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0);
   endtask

   task automatic test_reset_midshift();
      send_op(4'b1000, 32'hFFFF_0000, 32'd20);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, out_err, busy, in_ready} !== 4'b0001 || out_result !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_midshift: v/e/busy/rdy=%b%b%b%b res=%h required 0001 res=0",
                  out_valid, out_err, busy, in_ready, out_result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("xor_after_reset", 4'b0010, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_F0F0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_arith();
      test_compare_illegal();
      test_shifts();
      test_backpressure();
      test_flush();
      test_random();
      test_reset_midshift();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
